grf_write_arbiter: RTL and testbench
====================================

# grf_write_arbiter

Shares the GRF's single byte-enabled write port between three producers: the W-stage pipeline writeback (port 0), the multiply/divide unit result (port 1) and the uncached/long-latency load return (port 2). It sits between those producers and the GRF write port (WriteAddr/WriteEnable/WriteData) and registers the winning beat for a single-cycle GRF write. The GRF's internal same-cycle read bypass still applies to the registered output. An optional starvation guard stalls the W stage so side producers are guaranteed service.

## Interface
Parameters:
- MAX_WAIT, 8, cycles a pending side request may be refused before the starvation guard forces its grant (1..255).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clr_n  in  1  asynchronous, active-low reset.
- W_WE  in  4  port 0 byte enables; nonzero means write request.
- W_Addr  in  5  port 0 destination register.
- W_Data  in  32  port 0 write data.
- W_PC  in  32  port 0 instruction PC (debug pass-through).
- Stall_W  out  1  holds the W stage; port 0 must keep its inputs stable while high.
- S_Req[1:2]  in  1 each  side request; held with payload stable until granted.
- S_Addr[1:2]  in  5 each  side destination register.
- S_BE[1:2]  in  4 each  side byte enables; must be nonzero while S_Req is high.
- S_Data[1:2]  in  32 each  side write data.
- S_Gnt[1:2]  out  1 each  combinational grant; transfer when S_Req && S_Gnt.
- Out_WE  out  4  registered GRF WriteEnable.
- Out_Addr  out  5  registered GRF WriteAddr.
- Out_Data  out  32  registered GRF WriteData.
- Out_PC  out  32  registered PC of the beat (zero for side beats).

## Operation
- Winner each cycle, in priority order:
  - forced side port (guard fired): oldest-waiting side port; on tie, the side port selected by rr.
  - port 0 if W_WE != 0.
  - side request, choosing S_Req[rr] first and otherwise the other port.
- rr: 1-bit round-robin pointer. Reset value selects port 1. Flips to the other side port after any side grant.
- Side ports with S_Req high and no grant increment their wait counter, saturating at MAX_WAIT. The counter clears on grant or when S_Req is low.
- Guard fires when a side port's counter equals MAX_WAIT. That cycle: Stall_W=1, port 0 is not accepted, and the forced side port is granted.
- Writes to Addr 0: accepted and granted normally, but the registered Out_WE is forced to 0.
- No WAW ordering between ports; the upstream scoreboard guarantees distinct destinations for concurrent writes.

## Timing
- One-cycle latency: the beat accepted in cycle N appears on Out_* in cycle N+1. The GRF commits it at the end of N+1.
- Out_WE=0 in any cycle following one with no accepted beat.
- S_Gnt and Stall_W are combinational from S_Req, W_WE and state; there is no combinational path from Out_*.
- Reset (asynchronous, any time, including mid-wait) sets:
  - Out_WE=0, Out_Addr=0, Out_Data=0, Out_PC=0.
  - All wait counters to 0; rr to port 1.
  - Outputs are driven with Stall_W=0 and S_Gnt=0 while Clr_n is low.
- Simultaneous W_WE and both S_Req with neither counter saturated: port 0 wins, and both counters increment.
- S_Req dropped before grant is a protocol violation; the counter clears and no beat is lost from the arbiter's view.

## Configuration
- GRF_ARB_STARVE_GUARD_EN defined: wait counters, MAX_WAIT forcing and Stall_W are implemented as above.
- Not defined: counters are removed, and Stall_W is tied 0. Side ports are granted only in cycles with W_WE == 0. MAX_WAIT is ignored.

## Structure
- Shared package grf_arb_pkg holds:
  - port index constants PORT_W=0, PORT_MD=1, PORT_LD=2.
  - typedef grf_wbeat_t {addr[4:0], be[3:0], data[31:0], pc[31:0]}.
  - the NUM_SIDE=2 constant.
- Sub-module grf_arb_wait_ctr, one instance per side port: saturating wait counter with a `starved` output. It is compiled only under GRF_ARB_STARVE_GUARD_EN.

## Test plan
- Port 0 writes {WE=4'hF, Addr=5, Data=32'hDEADBEEF} with no side traffic -> next cycle Out_WE=4'hF, Out_Addr=5, Out_Data=32'hDEADBEEF, Out_PC=W_PC; Stall_W=0.
- Both side ports request with port 0 idle for 4 cycles, payloads held until granted -> grants alternate 1,2,1,2 and each beat appears one cycle after its grant.
- Port 0 busy every cycle with S_Req[1] held, MAX_WAIT=8, guard enabled -> S_Gnt[1]=0 for 8 cycles. On cycle 9: Stall_W=1 and S_Gnt[1]=1, and the stalled port 0 beat is written on the cycle after.
- Same stimulus with guard disabled -> Stall_W stays 0 and S_Gnt[1] stays 0 until W_WE=0.
- Port 0 writes Addr=0, WE=4'hF -> next cycle Out_WE=0.
- Clr_n pulsed low for 1 cycle while port 2's counter=5 -> all Out_*=0 and the counter restarts from 0. After release, port 1 has first side priority.

Source files
------------

// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
// Port indices, side-port count, wait-counter width and the beat bundle.
package grf_arb_pkg;

    localparam logic [1:0] PORT_W   = 2'd0;
    localparam logic [1:0] PORT_MD  = 2'd1;
    localparam logic [1:0] PORT_LD  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam int NUM_SIDE = 2;
    localparam int WAIT_W   = 8;

    typedef struct packed {
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] pc;
    } grf_wbeat_t;

endpackage

// File: rtl/grf_arb_wait_ctr.sv
// Saturating wait counter for one side port (built with GRF_ARB_STARVE_GUARD_EN).
// Ports: clk, rst_n, req, gnt in; starved out (req held and count at MAX_WAIT).
`ifdef GRF_ARB_STARVE_GUARD_EN
module grf_arb_wait_ctr
    import grf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    // Gated by req so a stale count never forces a grant nobody asked for.
    assign starved = req && (count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!req || gnt) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/grf_write_arbiter.sv
// Arbitrates the GRF write port between W-stage writeback and two side producers.
// Ports: Clk/Clr_n; W_* port 0 in, Stall_W out; S_* side req/payload in, S_Gnt out;
// Out_* registered GRF write. Optional guard macro: GRF_ARB_STARVE_GUARD_EN.
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic                          Clk,
    input  logic                          Clr_n,
    input  logic [3:0]                    W_WE,
    input  logic [4:0]                    W_Addr,
    input  logic [31:0]                   W_Data,
    input  logic [31:0]                   W_PC,
    output logic                          Stall_W,
    input  logic [1:NUM_SIDE]             S_Req,
    input  logic [1:NUM_SIDE][4:0]        S_Addr,
    input  logic [1:NUM_SIDE][3:0]        S_BE,
    input  logic [1:NUM_SIDE][31:0]       S_Data,
    output logic [1:NUM_SIDE]             S_Gnt,
    output logic [3:0]                    Out_WE,
    output logic [4:0]                    Out_Addr,
    output logic [31:0]                   Out_Data,
    output logic [31:0]                   Out_PC
);

    logic [1:NUM_SIDE] starved;
    logic [1:0]        sel;
    logic              stall_c;
    logic              rr;
    grf_wbeat_t        beat;
    grf_wbeat_t        out_q;

`ifdef GRF_ARB_STARVE_GUARD_EN
    for (genvar i = 1; i <= NUM_SIDE; i++) begin : g_wait
        grf_arb_wait_ctr #(
            .MAX_WAIT (MAX_WAIT)
        ) u_ctr (
            .clk     (Clr_n ? Clk : Clk),
            .rst_n   (Clr_n),
            .req     (S_Req[i]),
            .gnt     (S_Gnt[i]),
            .starved (starved[i])
        );
    end
`else
    logic [7:0] unused_max_wait;
    assign unused_max_wait = 8'(MAX_WAIT);
    assign starved = '0;
`endif

    // rr == 0 favours the multiply/divide port, rr == 1 the load port.
    always_comb begin
        sel     = SEL_NONE;
        stall_c = 1'b0;
        if (Clr_n) begin
            priority case (1'b1)
                (|starved): begin
                    stall_c = 1'b1;
                    if (starved[PORT_MD] && (!starved[PORT_LD] || !rr))
                        sel = PORT_MD;
                    else
                        sel = PORT_LD;
                end
                (|W_WE): begin
                    sel = PORT_W;
                end
                (|S_Req): begin
                    if (S_Req[PORT_MD] && (!rr || !S_Req[PORT_LD]))
                        sel = PORT_MD;
                    else
                        sel = PORT_LD;
                end
                default: begin
                    sel = SEL_NONE;
                end
            endcase
        end
    end

    assign Stall_W         = stall_c;
    assign S_Gnt[PORT_MD]  = (sel == PORT_MD);
    assign S_Gnt[PORT_LD]  = (sel == PORT_LD);

    always_comb begin
        beat = '0;
        unique case (sel)
            PORT_W: begin
                beat = '{addr: W_Addr, be: W_WE, data: W_Data, pc: W_PC};
            end
            PORT_MD: begin
                beat = '{addr: S_Addr[PORT_MD], be: S_BE[PORT_MD],
                         data: S_Data[PORT_MD], pc: 32'h0};
            end
            PORT_LD: begin
                beat = '{addr: S_Addr[PORT_LD], be: S_BE[PORT_LD],
                         data: S_Data[PORT_LD], pc: 32'h0};
            end
            default: begin
                beat = '0;
            end
        endcase
        // r0 is hardwired zero: keep the beat but suppress the write.
        if (beat.addr == 5'd0)
            beat.be = 4'h0;
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            out_q <= '0;
            rr    <= 1'b0;
        end else begin
            out_q <= beat;
            if (sel == PORT_MD)
                rr <= 1'b1;
            else if (sel == PORT_LD)
                rr <= 1'b0;
        end
    end

    assign Out_WE   = out_q.be;
    assign Out_Addr = out_q.addr;
    assign Out_Data = out_q.data;
    assign Out_PC   = out_q.pc;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: reference model plus beat scoreboard.
// Directed scenarios cover priority, round-robin, starvation guard, r0 and reset.
module tb_grf_write_arbiter;

    localparam int MAXW = 8;
`ifdef GRF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Clr_n;
    logic [3:0]        W_WE;
    logic [4:0]        W_Addr;
    logic [31:0]       W_Data;
    logic [31:0]       W_PC;
    logic              Stall_W;
    logic [1:2]        S_Req;
    logic [1:2][4:0]   S_Addr;
    logic [1:2][3:0]   S_BE;
    logic [1:2][31:0]  S_Data;
    logic [1:2]        S_Gnt;
    logic [3:0]        Out_WE;
    logic [4:0]        Out_Addr;
    logic [31:0]       Out_Data;
    logic [31:0]       Out_PC;

    grf_write_arbiter #(.MAX_WAIT(MAXW)) dut (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .W_WE     (W_WE),
        .W_Addr   (W_Addr),
        .W_Data   (W_Data),
        .W_PC     (W_PC),
        .Stall_W  (Stall_W),
        .S_Req    (S_Req),
        .S_Addr   (S_Addr),
        .S_BE     (S_BE),
        .S_Data   (S_Data),
        .S_Gnt    (S_Gnt),
        .Out_WE   (Out_WE),
        .Out_Addr (Out_Addr),
        .Out_Data (Out_Data),
        .Out_PC   (Out_PC)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt [1:2];
    bit   m_rr;

    logic [1:2]  seen_gnt;
    logic        seen_stall;
    logic [3:0]  seen_we;
    logic [4:0]  seen_addr;
    logic [31:0] seen_data;
    logic [31:0] seen_pc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        exp_t       e;
        exp_t       n;
        int         pick;
        bit         st;
        bit         s1;
        bit         s2;
        logic [1:2] eg;
        @(negedge Clk);
        pick = 3;
        st   = 1'b0;
        if (Clr_n) begin
            s1 = GUARD && S_Req[1] && (m_cnt[1] == MAXW);
            s2 = GUARD && S_Req[2] && (m_cnt[2] == MAXW);
            if (s1 || s2) begin
                st   = 1'b1;
                pick = (s1 && s2) ? (m_rr ? 2 : 1) : (s1 ? 1 : 2);
            end else if (W_WE != 4'h0) begin
                pick = 0;
            end else if (S_Req[1] && S_Req[2]) begin
                pick = m_rr ? 2 : 1;
            end else if (S_Req[1]) begin
                pick = 1;
            end else if (S_Req[2]) begin
                pick = 2;
            end
        end
        eg = {pick == 1, pick == 2};
        check("stall_w", 32'(Stall_W), 32'(st));
        check("s_gnt", 32'(S_Gnt), 32'(eg));

        e = '{we: 4'h0, addr: 5'h0, data: 32'h0, pc: 32'h0, full: 1'b1};
        if (!Clr_n) begin
            sb.delete();
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e.full = 1'b0;
        end
        check("out_we", 32'(Out_WE), 32'(e.we));
        if (e.full) begin
            check("out_addr", 32'(Out_Addr), 32'(e.addr));
            check("out_data", Out_Data, e.data);
            check("out_pc", Out_PC, e.pc);
        end

        n = '{we: 4'h0, addr: 5'h0, data: 32'h0, pc: 32'h0, full: 1'b1};
        if (pick == 0) begin
            n.we   = (W_Addr == 5'd0) ? 4'h0 : W_WE;
            n.addr = W_Addr;
            n.data = W_Data;
            n.pc   = W_PC;
        end else if (pick == 1 || pick == 2) begin
            n.we   = (S_Addr[pick] == 5'd0) ? 4'h0 : S_BE[pick];
            n.addr = S_Addr[pick];
            n.data = S_Data[pick];
        end else if (Clr_n) begin
            n.full = 1'b0;
        end
        sb.push_back(n);

        if (!Clr_n) begin
            m_cnt[1] = 0;
            m_cnt[2] = 0;
            m_rr     = 1'b0;
        end else begin
            for (int i = 1; i <= 2; i++) begin
                if (GUARD && S_Req[i] && pick != i)
                    m_cnt[i] = (m_cnt[i] < MAXW) ? m_cnt[i] + 1 : MAXW;
                else
                    m_cnt[i] = 0;
            end
            if (pick == 1)
                m_rr = 1'b1;
            else if (pick == 2)
                m_rr = 1'b0;
        end

        seen_gnt   = S_Gnt;
        seen_stall = Stall_W;
        seen_we    = Out_WE;
        seen_addr  = Out_Addr;
        seen_data  = Out_Data;
        seen_pc    = Out_PC;
        @(posedge Clk);
        #1;
    endtask

    task automatic w_next();
        W_Addr = (W_Addr == 5'd31) ? 5'd1 : W_Addr + 5'd1;
        W_Data = $urandom;
        W_PC   = W_PC + 32'd4;
    endtask

    int  seq[$];
    int  exp_seq [4];
    int  waits;
    bit  got;
    bit  stall_at_gnt;
    bit  ever_stall;

    initial begin
        exp_seq = '{1, 2, 1, 2};
        m_cnt[1] = 0;
        m_cnt[2] = 0;
        m_rr     = 1'b0;
        Clr_n  = 1'b1;
        W_WE   = 4'hF;
        W_Addr = 5'd3;
        W_Data = 32'h1234_5678;
        W_PC   = 32'h0000_0100;
        S_Req  = 2'b11;
        S_Addr = '{5'd7, 5'd9};
        S_BE   = '{4'hF, 4'hF};
        S_Data = '{32'hA000_0001, 32'hB000_0001};
        #1 Clr_n = 1'b0;

        // reset with all producers requesting
        cycle();
        cycle();
        Clr_n = 1'b1;
        W_WE  = 4'h0;
        S_Req = 2'b00;
        cycle();

        // plain port 0 write
        W_WE   = 4'hF;
        W_Addr = 5'd5;
        W_Data = 32'hDEAD_BEEF;
        W_PC   = 32'h0000_1000;
        cycle();
        W_WE = 4'h0;
        cycle();
        check("t1_we", 32'(seen_we), 32'hF);
        check("t1_addr", 32'(seen_addr), 32'd5);
        check("t1_data", seen_data, 32'hDEAD_BEEF);
        check("t1_pc", seen_pc, 32'h0000_1000);

        // both side ports, port 0 idle: round-robin
        S_Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (seen_gnt[1]) begin
                seq.push_back(1);
                S_Data[1] = S_Data[1] + 32'd1;
            end
            if (seen_gnt[2]) begin
                seq.push_back(2);
                S_Data[2] = S_Data[2] + 32'd1;
            end
        end
        S_Req = 2'b00;
        cycle();
        check("rr_count", 32'(seq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check("rr_order", (k < seq.size()) ? 32'(seq[k]) : 32'hFFFF_FFFF,
                  32'(exp_seq[k]));

        // port 0 busy, side port 1 held
        S_Req     = 2'b10;
        S_Addr[1] = 5'd11;
        S_BE[1]   = 4'h3;
        S_Data[1] = 32'h1111_0000;
        W_WE      = 4'hF;
        w_next();
        waits        = 0;
        got          = 1'b0;
        stall_at_gnt = 1'b0;
        ever_stall   = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            cycle();
            ever_stall = ever_stall | seen_stall;
            if (seen_gnt[1]) begin
                got          = 1'b1;
                stall_at_gnt = seen_stall;
                S_Req[1]     = 1'b0;
            end else begin
                waits++;
            end
            if (!seen_stall)
                w_next();
        end
`ifdef GRF_ARB_STARVE_GUARD_EN
        check("guard_waits", 32'(waits), 32'(MAXW));
        check("guard_gnt", 32'(got), 32'd1);
        check("guard_stall", 32'(stall_at_gnt), 32'd1);
        cycle();
        check("guard_unstall", 32'(seen_stall), 32'd0);
        W_WE = 4'h0;
        cycle();
`else
        check("noguard_waits", 32'(waits), 32'd12);
        check("noguard_stall", 32'(ever_stall), 32'd0);
        W_WE = 4'h0;
        cycle();
        check("noguard_gnt", 32'(seen_gnt[1]), 32'd1);
        S_Req[1] = 1'b0;
`endif
        cycle();

        // write to r0 suppressed
        W_WE   = 4'hF;
        W_Addr = 5'd0;
        W_Data = 32'h5555_5555;
        cycle();
        W_WE = 4'h0;
        cycle();
        check("r0_we", 32'(seen_we), 32'd0);

        // reset mid-wait with side port 2 pending
        S_Req     = 2'b01;
        S_Addr[2] = 5'd13;
        S_BE[2]   = 4'hC;
        S_Data[2] = 32'h2222_0000;
        W_WE      = 4'hF;
        W_Addr    = 5'd20;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (!seen_stall)
                w_next();
        end
        Clr_n = 1'b0;
        cycle();
        check("rst_we", 32'(seen_we), 32'd0);
        check("rst_data", seen_data, 32'd0);
        Clr_n = 1'b1;
        W_WE  = 4'h0;
        S_Req = 2'b11;
        cycle();
        check("rst_rr", 32'(seen_gnt), 32'(2'b10));
        S_Req[1] = 1'b0;
        W_WE     = 4'hF;
        waits = seen_gnt[2] ? 0 : 1;
        got   = seen_gnt[2];
        for (int k = 0; k < 12 && !got; k++) begin
            cycle();
            if (seen_gnt[2]) begin
                got      = 1'b1;
                S_Req[2] = 1'b0;
            end else begin
                waits++;
            end
            if (!seen_stall)
                w_next();
        end
`ifdef GRF_ARB_STARVE_GUARD_EN
        check("rst_restart", 32'(waits), 32'(MAXW));
`else
        check("rst_nogrant", 32'(got), 32'd0);
`endif
        S_Req = 2'b00;
        W_WE  = 4'h0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
